ip_scan_ctrl: RTL

- Sequencer for the switch/button input peripheral region at 0x7800–0x782F.
- Periodically samples raw switches and buttons and debounces them by requiring several consecutive identical samples.
- Latches button rising edges into a sticky event register.
- Serves single-cycle-request / registered-ack reads from the LSU for the debounced values and the event register.

---
 rtl/ip_scan_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ip_scan_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ip_scan_ctrl
//
// Scan sequencer for the switch/button peripheral window (0x7800-0x782F).
// Every SCAN_PERIOD idle cycles the FSM runs one 3-cycle scan:
// SAMPLE -> COMPARE -> COMMIT.
//   SAMPLE  : capture the raw switch/button levels.
//   COMPARE : compare against the previous capture. A match advances the
//             stable counter (saturating). A difference restarts it and
//             replaces the reference capture.
//   COMMIT  : once the counter has saturated, the reference capture becomes
//             the debounced value. Button rising edges are ORed into a sticky
//             event register.
// The LSU read port is independent of the scan FSM. A request sampled at
// edge N is acknowledged for exactly one cycle (N+1). Reading 0x7820 returns
// the event register and clears the returned bits.
//
// Parameters
//   SCAN_PERIOD  idle cycles between scans (>= 1)
//   STABLE_CNT   consecutive identical scans before the debounced value moves (>= 1)
//
// Optional build macro
//   IP_SCAN_SYNC_EN  when defined, i_io_sw / i_io_btn each pass through a
//                    2-flop synchronizer ahead of SAMPLE.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous, active-high reset
//   i_io_sw      raw switch levels
//   i_io_btn     raw button levels (1 = pressed)
//   i_rd_req     one-cycle read request
//   i_rd_addr    read address, valid with i_rd_req
//   o_rd_ack     one-cycle read acknowledge
//   o_rd_data    read data, 0 whenever o_rd_ack is low
//   o_btn_evt    high while any event bit is set
//   o_scan_busy  high during SAMPLE / COMPARE / COMMIT
// ----------------------------------------------------------------------------
module ip_scan_ctrl #(
    parameter int unsigned SCAN_PERIOD = 1000,
    parameter int unsigned STABLE_CNT  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_io_sw,
    input  logic [31:0] i_io_btn,
    input  logic        i_rd_req,
    input  logic [15:0] i_rd_addr,
    output logic        o_rd_ack,
    output logic [31:0] o_rd_data,
    output logic        o_btn_evt,
    output logic        o_scan_busy
);

    localparam int unsigned PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int unsigned STB_W = (STABLE_CNT  > 1) ? $clog2(STABLE_CNT)  : 1;
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(SCAN_PERIOD - 1);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_CNT - 1);

    localparam logic [15:0] ADDR_SW  = 16'h7800;
    localparam logic [15:0] ADDR_BTN = 16'h7810;
    localparam logic [15:0] ADDR_EVT = 16'h7820;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_COMPARE,
        ST_COMMIT
    } state_e;

    state_e           state_q;
    logic [PER_W-1:0] per_cnt_q;
    logic [STB_W-1:0] stb_cnt_q;
    logic [31:0]      new_sw_q, new_btn_q;
    logic [31:0]      sw_smp_q, btn_smp_q;
    logic [31:0]      sw_db_q,  btn_db_q;
    logic [31:0]      evt_q,    evt_d;
    logic             evt_any_q;
    logic             busy_q;
    logic             rd_ack_q;
    logic [31:0]      rd_data_q, rd_data_d;
    logic [31:0]      rd_clear;
    logic [31:0]      new_edges;
    logic             commit_hit;
    logic [31:0]      sw_in, btn_in;

    // ------------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------------
`ifdef IP_SCAN_SYNC_EN
    logic [31:0] sw_sync1_q, sw_sync2_q;
    logic [31:0] btn_sync1_q, btn_sync2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            btn_sync1_q <= '0;
            btn_sync2_q <= '0;
        end else begin
            sw_sync1_q  <= i_io_sw;
            sw_sync2_q  <= sw_sync1_q;
            btn_sync1_q <= i_io_btn;
            btn_sync2_q <= btn_sync1_q;
        end
    end

    assign sw_in  = sw_sync2_q;
    assign btn_in = btn_sync2_q;
`else
    assign sw_in  = i_io_sw;
    assign btn_in = i_io_btn;
`endif

    // ------------------------------------------------------------------------
    // Read decode and event-register next state.
    // A clear-on-read and a COMMIT can land on the same edge. The bits that
    // were returned are dropped, and edges found by this COMMIT survive so
    // that no button press is lost.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rd_data_d  = '0;
        rd_clear   = '0;
        commit_hit = (state_q == ST_COMMIT) && (stb_cnt_q == STB_MAX);
        new_edges  = commit_hit ? (btn_smp_q & ~btn_db_q) : '0;

        if (i_rd_req) begin
            case (i_rd_addr)
                ADDR_SW:  rd_data_d = sw_db_q;
                ADDR_BTN: rd_data_d = btn_db_q;
                ADDR_EVT: begin
                    rd_data_d = evt_q;
                    rd_clear  = evt_q;
                end
                default:  rd_data_d = '0;
            endcase
        end

        evt_d = (evt_q & ~rd_clear) | new_edges;
    end

    // ------------------------------------------------------------------------
    // Scan FSM, debounce state, event register and read response
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from the values they held before
        // the edge.
        if (i_rst) begin
            // NOTE: the data registers are reset along with the control
            // registers, because every output and every readable register
            // must read 0 straight after reset.
            state_q   <= ST_IDLE;
            per_cnt_q <= '0;
            stb_cnt_q <= '0;
            new_sw_q  <= '0;
            new_btn_q <= '0;
            sw_smp_q  <= '0;
            btn_smp_q <= '0;
            sw_db_q   <= '0;
            btn_db_q  <= '0;
            evt_q     <= '0;
            evt_any_q <= 1'b0;
            busy_q    <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q  <= i_rd_req;
            rd_data_q <= rd_data_d;
            evt_q     <= evt_d;
            evt_any_q <= |evt_d;

            case (state_q)
                ST_IDLE: begin
                    if (per_cnt_q == PER_MAX) begin
                        per_cnt_q <= '0;
                        state_q   <= ST_SAMPLE;
                        busy_q    <= 1'b1;
                    end else begin
                        per_cnt_q <= per_cnt_q + PER_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    new_sw_q  <= sw_in;
                    new_btn_q <= btn_in;
                    state_q   <= ST_COMPARE;
                end

                ST_COMPARE: begin
                    if ({new_sw_q, new_btn_q} == {sw_smp_q, btn_smp_q}) begin
                        if (stb_cnt_q != STB_MAX) begin
                            stb_cnt_q <= stb_cnt_q + STB_W'(1);
                        end
                    end else begin
                        // A differing capture restarts the debounce window
                        // and becomes the new reference.
                        stb_cnt_q <= '0;
                        sw_smp_q  <= new_sw_q;
                        btn_smp_q <= new_btn_q;
                    end
                    state_q <= ST_COMMIT;
                end

                ST_COMMIT: begin
                    if (commit_hit) begin
                        sw_db_q  <= sw_smp_q;
                        btn_db_q <= btn_smp_q;
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_ack    = rd_ack_q;
    assign o_rd_data   = rd_data_q;
    assign o_btn_evt   = evt_any_q;
    assign o_scan_busy = busy_q;

endmodule
